// File: rtl/canon_voice_sequencer.sv
// Four-voice round sequencer: plays a 32-step divider table on each voice,
// staggering voice entries by VOICE_OFFSET steps, with registered per-voice dividers.
module canon_voice_sequencer #(
  parameter int unsigned STEP_CLKS    = 6250000,
  parameter int unsigned GAP_CLKS     = 625000,
  parameter int unsigned VOICE_OFFSET = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [11:0] cfg_data,
  output logic        busy,
  output logic [47:0] voice_div,
  output logic [3:0]  voice_active,
  output logic [4:0]  step_idx,
  output logic        step_strobe
);

  localparam logic [23:0] LAST_T = 24'(STEP_CLKS - 1);
  localparam logic [23:0] ON_T   = 24'(STEP_CLKS - GAP_CLKS);

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [6:0]  g_q, g_d;
  logic [4:0]  pos_q [4];
  logic [4:0]  pos_d [4];
  logic [3:0]  active_q, active_d;
  logic [3:0]  done_q, done_d;
  logic [47:0] div_q, div_d;
  logic        strobe_q, strobe_d;
  logic        clear_all;
  logic        tbl_we;
  logic [11:0] rdata [4];
  logic [11:0] table_q [32];

  assign tbl_we = cfg_we && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    g_d       = g_q;
    pos_d     = pos_q;
    active_d  = active_q;
    done_d    = done_q;
    strobe_d  = 1'b0;
    clear_all = 1'b0;
    div_d     = '0;
    for (int unsigned v = 0; v < 4; v++) begin
      rdata[v] = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d  = S_PLAY;
          timer_d  = '0;
          g_d      = '0;
          done_d   = '0;
          active_d = 4'b0001;
          for (int unsigned v = 0; v < 4; v++) begin
            pos_d[v] = '0;
          end
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d   = S_IDLE;
          clear_all = 1'b1;
        end else if (timer_q == LAST_T) begin
          timer_d  = '0;
          strobe_d = 1'b1;
          g_d      = (g_q == 7'd127) ? g_q : g_q + 7'd1;
          for (int unsigned v = 0; v < 4; v++) begin
            if (active_q[v]) begin
              pos_d[v] = pos_q[v] + 5'd1;
              if (pos_q[v] == 5'd31 && !loop_en) begin
                active_d[v] = 1'b0;
                done_d[v]   = 1'b1;
              end
            end else if (!done_q[v] && g_d == 7'(v * VOICE_OFFSET)) begin
              active_d[v] = 1'b1;
              pos_d[v]    = '0;
            end
          end
          // Last voice finishing ends playback; the boundary strobe still fires.
          if (done_d[3] && !done_q[3]) begin
            state_d   = S_IDLE;
            clear_all = 1'b1;
          end
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        clear_all = 1'b1;
      end
    endcase

    if (clear_all) begin
      timer_d  = '0;
      g_d      = '0;
      active_d = '0;
      done_d   = '0;
      for (int unsigned v = 0; v < 4; v++) begin
        pos_d[v] = '0;
      end
    end

    // A write coinciding with start is forwarded so step 0 sees the new value.
    for (int unsigned v = 0; v < 4; v++) begin
      rdata[v] = (tbl_we && cfg_addr == pos_d[v]) ? cfg_data : table_q[pos_d[v]];
      if (state_d == S_PLAY && active_d[v] && timer_d < ON_T) begin
        div_d[12*v +: 12] = rdata[v];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      g_q      <= '0;
      active_q <= '0;
      done_q   <= '0;
      div_q    <= '0;
      strobe_q <= 1'b0;
      for (int unsigned v = 0; v < 4; v++) begin
        pos_q[v] <= '0;
      end
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      g_q      <= g_d;
      active_q <= active_d;
      done_q   <= done_d;
      div_q    <= div_d;
      strobe_q <= strobe_d;
      for (int unsigned v = 0; v < 4; v++) begin
        pos_q[v] <= pos_d[v];
      end
    end
  end

  assign busy         = (state_q == S_PLAY);
  assign voice_div    = div_q;
  assign voice_active = active_q;
  assign step_idx     = pos_q[0];
  assign step_strobe  = strobe_q;

endmodule

// File: tb/tb_canon_voice_sequencer.sv
// Randomized bench for canon_voice_sequencer: two instances (gapped and legato)
// compared each cycle against an elapsed-time reference model of the round.
module tb_canon_voice_sequencer;

  localparam int STEP = 8;
  localparam int GAP  = 2;
  localparam int OFF  = 2;

  logic        clk;
  logic        rst, start, stop, loop_en, cfg_we;
  logic [4:0]  cfg_addr;
  logic [11:0] cfg_data;

  logic        busy_a, strb_a, busy_b, strb_b;
  logic [47:0] div_a, div_b;
  logic [3:0]  act_a, act_b;
  logic [4:0]  idx_a, idx_b;

  canon_voice_sequencer #(.STEP_CLKS(STEP), .GAP_CLKS(GAP), .VOICE_OFFSET(OFF)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy_a), .voice_div(div_a), .voice_active(act_a),
    .step_idx(idx_a), .step_strobe(strb_a)
  );

  canon_voice_sequencer #(.STEP_CLKS(STEP), .GAP_CLKS(0), .VOICE_OFFSET(OFF)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy_b), .voice_div(div_b), .voice_active(act_b),
    .step_idx(idx_b), .step_strobe(strb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: playback described by cycles elapsed since start.
  bit          m_play   = 1'b0;
  int          m_t      = 0;
  bit [3:0]    m_fin    = '0;
  bit          m_strobe = 1'b0;
  logic [11:0] m_tab [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
  endtask

  task automatic model_edge();
    int s, rel;
    m_strobe = 1'b0;
    if (rst) begin
      m_play = 1'b0; m_t = 0; m_fin = '0;
      return;
    end
    if (!m_play) begin
      if (cfg_we) m_tab[cfg_addr] = cfg_data;
      if (start && !stop) begin
        m_play = 1'b1; m_t = 0; m_fin = '0;
      end
    end else if (stop) begin
      m_play = 1'b0;
    end else begin
      m_t++;
      if (m_t % STEP == 0) begin
        m_strobe = 1'b1;
        s = m_t / STEP;
        for (int v = 0; v < 4; v++) begin
          rel = s - v * OFF;
          if (rel > 0 && rel % 32 == 0 && !loop_en) m_fin[v] = 1'b1;
        end
        if (m_fin[3]) m_play = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic [47:0] ea, eb;
    logic [3:0]  eact;
    logic [4:0]  eidx;
    int s, ph, rel;
    ea = '0; eb = '0; eact = '0; eidx = '0;
    s = m_t / STEP;
    ph = m_t % STEP;
    for (int v = 0; v < 4; v++) begin
      rel = s - v * OFF;
      if (m_play && rel >= 0 && !m_fin[v]) begin
        eact[v] = 1'b1;
        eb[12*v +: 12] = m_tab[rel % 32];
        if (ph < STEP - GAP) ea[12*v +: 12] = m_tab[rel % 32];
      end
    end
    if (m_play && !m_fin[0]) eidx = 5'(s % 32);
    chk("busy", busy_a, m_play);
    chk("busy_b", busy_b, m_play);
    chk("active", act_a, eact);
    chk("active_b", act_b, eact);
    chk("step_idx", idx_a, eidx);
    chk("strobe", strb_a, m_strobe);
    chk("strobe_b", strb_b, m_strobe);
    chk("div", div_a, ea);
    chk("div_legato", div_b, eb);
  endtask

  task automatic cyc(input logic r, input logic st, input logic sp, input logic le,
                     input logic we, input logic [4:0] a, input logic [11:0] d);
    rst = r; start = st; stop = sp; loop_en = le;
    cfg_we = we; cfg_addr = a; cfg_data = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input logic le);
    cyc(1'b0, 1'b0, 1'b0, le, 1'b0, 5'd0, 12'd0);
  endtask

  initial begin
    int cnt, v0_end;
    for (int i = 0; i < 32; i++) m_tab[i] = '0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;

    // Reset with random noise on the other inputs
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
          5'($urandom), 12'($urandom));

    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'(i), 12'(100 + i));

    // One-shot playback to completion
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
    cnt = 0; v0_end = -1;
    while (busy_a && cnt < 400) begin
      idle(1'b0);
      cnt++;
      if (v0_end < 0 && !act_a[0]) v0_end = cnt;
    end
    chk("v0_len", v0_end, 256);
    chk("oneshot_len", cnt, 304);

    // Loop mode with ignored starts and table writes during play
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 12'd0);
    for (int i = 0; i < 420; i++)
      cyc(1'b0, 1'($urandom_range(0, 15) == 0), 1'b0, 1'b1,
          1'($urandom_range(0, 7) == 0), 5'd0, 12'd999);
    chk("loop_busy", busy_a, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 12'd0);

    // start and stop together in idle
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 12'd0);
    idle(1'b0);

    // stop landing on a step boundary
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
    for (int i = 0; i < 3 * STEP - 1; i++) idle(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 12'd0);
    idle(1'b0);

    // Reset at step 5, then restart from the preserved table
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
    for (int i = 0; i < 5 * STEP; i++) idle(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
    chk("restart_div", div_a[11:0], 12'd100);
    for (int i = 0; i < 20; i++) idle(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 12'd0);

    // Randomized episodes; start coincides with a write to address 0
    for (int ep = 0; ep < 8; ep++) begin
      for (int i = 0; i < 4; i++)
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'($urandom), 12'($urandom));
      cyc(1'b0, 1'b1, 1'b0, 1'($urandom), 1'b1, 5'd0, 12'($urandom));
      for (int i = 0; i < 500; i++) begin
        logic r;
        r = ($urandom_range(0, 999) == 0);
        cyc(r, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 399) == 0),
            1'($urandom_range(0, 3) != 0), r ? 1'b0 : 1'($urandom_range(0, 7) == 0),
            5'($urandom), 12'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/canon_voice_sequencer.md
Name: canon_voice_sequencer

Overview:
- Sequences the four time-multiplexed voices of the PWM sample synth as a round (canon).
- Holds a 32-step melody table of divider values. Starts each voice VOICE_OFFSET steps after the previous one.
- Presents one registered 12-bit divider per voice to the sample generators. Divider 0 means silence; the generator outputs a 0x40 midpoint.
- Sits between the top-level control pins and the PWM sample datapath.

Parameters:
STEP_CLKS, 6250000, clocks per melody step (8 steps/s at 50 MHz); legal range 2..2^24-1.
GAP_CLKS, 625000, silent articulation clocks at the end of each step; legal range 0..STEP_CLKS-1.
VOICE_OFFSET, 8, steps between voice entries; legal range 1..42 (3*VOICE_OFFSET <= 127).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse, begins playback from IDLE
stop  in  1  one-cycle pulse, aborts playback
loop_en  in  1  1 = voices wrap the melody forever; sampled at each voice's wrap boundary
cfg_we  in  1  melody table write strobe
cfg_addr  in  5  melody table index
cfg_data  in  12  divider value to write
busy  out  1  1 while in PLAY
voice_div  out  48  voice v divider at [12v+11:12v]
voice_active  out  4  bit v = voice v entered and not finished
step_idx  out  5  voice 0 melody position
step_strobe  out  1  one-cycle pulse on every step boundary

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; busy, voice_div, voice_active, step_idx, step_strobe, timer, g, all pos_v, all done_v = 0. Melody table is not reset.
- Table writes: cfg_we writes table[cfg_addr] <= cfg_data, honoured only in IDLE; ignored in PLAY. A write and a start in the same IDLE cycle: the write takes effect, and a step-0 read of that address returns the new data.
- State IDLE:
  - start=1 and stop=0 -> PLAY.
  - On that same edge: timer=0, g=0, pos0=0, voice_active=4'b0001, busy=1, voice_div[11:0]=table[0].
  - start and stop together in IDLE: remain IDLE.
- State PLAY, timer:
  - timer counts 0..STEP_CLKS-1.
  - At STEP_CLKS-1 it wraps to 0, step_strobe=1 for the next cycle, and g increments, saturating at 127.
- State PLAY, step boundary, per voice v:
  - Inactive and not done, with new g == v*VOICE_OFFSET: becomes active with pos_v=0.
  - Already active: pos_v increments mod 32.
  - Wrapping 31->0 with loop_en=0: voice deactivates and sets done_v.
  - Wrapping 31->0 with loop_en=1: voice stays active.
- Outputs (registered, updated on the same edge as the state):
  - voice_div_v = table[pos_v] when voice v is active and timer < STEP_CLKS-GAP_CLKS; otherwise 0.
  - GAP_CLKS=0 gives legato output with no silent clocks.
  - step_idx = pos0.
- Completion: when voice 3 sets done (loop_en=0), the state goes to IDLE on that boundary edge. voice_active=0, voice_div=0, busy=0 in the following cycle.
- stop in PLAY: next edge -> IDLE, all outputs 0, all counters and done flags cleared. It takes priority over a coincident step boundary or start.
- start in PLAY: ignored.
- rst mid-PLAY: identical to power-on reset on the next edge. Table contents are preserved.
- Timer width: 24 bits; g width: 7 bits; pos_v: 5 bits each.
- Table read: asynchronous register-file read, 4 ports (one per voice).

Test Plan:
1. Reset behaviour. Drive random inputs with rst=1, then release -> busy=0, voice_div=0, voice_active=0, step_strobe=0.
2. Basic playback. STEP_CLKS=8, GAP_CLKS=2, OFFSET=2; table[i]=100+i; pulse start.
   - voice 0 divider reads 100 for 6 cycles, 0 for 2, then 101.
   - step_strobe pulses every 8 cycles.
   - At step 2, voice 1 shows 100 while voice 0 shows 102; voice_active=4'b0011.
3. One-shot completion. loop_en=0, same parameters.
   - voice 0 finishes after 32 steps (voice_active[0] falls 256 cycles after start).
   - Voice 3 finishes at step 38; busy falls 304 cycles after start, and all dividers are 0.
4. Loop mode. loop_en=1: voice 0 goes table[31]=131 -> table[0]=100, busy stays 1 past 400 cycles. Pulse stop -> next cycle voice_div=0, busy=0, voice_active=0.
5. Write gating and collisions.
   - cfg_we with addr 0, data 999 during PLAY is ignored (the next loop still plays 100).
   - start+stop in IDLE stays IDLE.
   - start during PLAY has no effect.
   - stop coincident with a step boundary -> IDLE.
6. Reset mid-play and legato.
   - rst asserted at step 5 -> all outputs 0 next cycle. Restart -> table preserved and playback starts at 100.
   - GAP_CLKS=0 -> divider never 0 while a voice is active.
